// File: rtl/cpu_drv_pkg.sv
// Shared definitions for the scripted CPU-side request driver:
// FSM state encoding, request-table entry layout and small helpers.
package cpu_drv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_REQ,
    ST_GAP,
    ST_DONE
  } drv_state_t;

  // Request table entry: {chk, rw, addr[23:0], data[7:0]}
  localparam int ENTRY_W = 34;
  localparam int CHK_BIT = 33;
  localparam int RW_BIT  = 32;
  localparam int ADDR_HI = 31;
  localparam int ADDR_LO = 8;
  localparam int DATA_HI = 7;
  localparam int DATA_LO = 0;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Build a table entry from its fields.
  function automatic logic [ENTRY_W-1:0] pack_entry(input logic chk, input logic rw,
                                                    input logic [23:0] addr,
                                                    input logic [7:0] data);
    return {chk, rw, addr, data};
  endfunction

  // Increment an 8-bit error counter, sticking at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/req_table.sv
// Request table: single write port plus one registered read port.
// Contents are intentionally not reset.
module req_table #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 34,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_reg [DEPTH];

  // Write when enabled; read every cycle with one cycle of latency (old data on collision).
  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
    rdata <= mem_reg[raddr];
  end

endmodule

// File: rtl/cpu_req_driver.sv
// Scripted CPU-port initiator: replays the request table over the
// ce_cpu/RDY_cpu handshake, checks read data and reports pass/fail.
module cpu_req_driver
  import cpu_drv_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int GAP_CYC     = 1,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [33:0]              prog_data,
  input  logic [$clog2(DEPTH):0]   num_req,
  input  logic                     start,
  output logic [23:0]              addr_cpu,
  output logic [7:0]               data_cpu_wr,
  input  logic [7:0]               data_cpu_rd,
  output logic                     rw_cpu,
  output logic                     ce_cpu,
  input  logic                     RDY_cpu,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [7:0]               err_cnt,
  output logic                     timeout,
  output logic [7:0]               last_rd
);

  localparam int IW = $clog2(DEPTH);
  localparam int NW = IW + 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  drv_state_t           state_reg;
  logic [IW-1:0]        idx_reg;
  logic [NW-1:0]        num_reg;
  logic [TW-1:0]        wait_cnt_reg;
  logic [GW-1:0]        gap_cnt_reg;
  logic                 start_reg;
  logic                 chk_reg;
  logic [IW-1:0]        rd_addr;
  logic [ENTRY_W-1:0]   entry;
  logic                 start_accept;
  logic                 last_entry;
  logic                 table_we;

  // The table can only be reprogrammed between runs.
  assign table_we     = prog_we && !busy;
  // A start is taken only when idle/done and no start is already pending.
  assign start_accept = start && !start_reg &&
                        (state_reg == ST_IDLE || state_reg == ST_DONE);
  assign last_entry   = ({1'b0, idx_reg} == (num_reg - NW'(1)));

  // Read address runs one step ahead so the entry is ready by the end of FETCH.
  always_comb begin
    rd_addr = idx_reg;
    if (state_reg == ST_IDLE || state_reg == ST_DONE) begin
      rd_addr = '0;
    end else if (state_reg == ST_GAP) begin
      rd_addr = idx_reg + IW'(1);
    end
  end

  req_table #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .AW    (IW)
  ) u_table (
    .clk   (clk),
    .we    (table_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (rd_addr),
    .rdata (entry)
  );

  // Run sequencer with all CPU-port and status outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      idx_reg      <= '0;
      num_reg      <= '0;
      wait_cnt_reg <= '0;
      gap_cnt_reg  <= '0;
      start_reg    <= 1'b0;
      chk_reg      <= 1'b0;
      addr_cpu     <= '0;
      data_cpu_wr  <= '0;
      rw_cpu       <= RW_READ;
      ce_cpu       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_cnt      <= '0;
      timeout      <= 1'b0;
      last_rd      <= '0;
    end else begin
      start_reg <= 1'b0;
      if (start_accept) begin
        start_reg <= 1'b1;
        num_reg   <= num_req;
      end

      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start_reg) begin
            idx_reg <= '0;
            done    <= 1'b0;
            pass    <= 1'b0;
            err_cnt <= '0;
            timeout <= 1'b0;
            if (num_reg == '0) begin
              state_reg <= ST_DONE;
              done      <= 1'b1;
              pass      <= 1'b1;
            end else begin
              state_reg <= ST_FETCH;
              busy      <= 1'b1;
            end
          end
        end

        ST_FETCH: begin
          addr_cpu     <= entry[ADDR_HI:ADDR_LO];
          data_cpu_wr  <= entry[DATA_HI:DATA_LO];
          rw_cpu       <= entry[RW_BIT];
          chk_reg      <= entry[CHK_BIT];
          ce_cpu       <= 1'b1;
          wait_cnt_reg <= '0;
          state_reg    <= ST_REQ;
        end

        ST_REQ: begin
          if (RDY_cpu) begin
            ce_cpu      <= 1'b0;
            gap_cnt_reg <= '0;
            state_reg   <= ST_GAP;
            if (rw_cpu == RW_READ) begin
              last_rd <= data_cpu_rd;
              if (chk_reg && (data_cpu_rd != data_cpu_wr)) begin
                err_cnt <= sat_inc8(err_cnt);
              end
            end
          end else if (wait_cnt_reg == TW'(TIMEOUT_CYC - 1)) begin
            ce_cpu    <= 1'b0;
            timeout   <= 1'b1;
            err_cnt   <= sat_inc8(err_cnt);
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= 1'b0;
            state_reg <= ST_DONE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + TW'(1);
          end
        end

        ST_GAP: begin
          if (gap_cnt_reg == GW'(GAP_CYC - 1)) begin
            if (last_entry) begin
              busy      <= 1'b0;
              done      <= 1'b1;
              pass      <= (err_cnt == '0);
              state_reg <= ST_DONE;
            end else begin
              idx_reg   <= idx_reg + IW'(1);
              state_reg <= ST_FETCH;
            end
          end else begin
            gap_cnt_reg <= gap_cnt_reg + GW'(1);
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/cpu_req_driver.md
# cpu_req_driver

Scripted CPU-side initiator for one `cache_l1` CPU port. It replays a preloaded table of byte read/write requests using the `ce_cpu`/`RDY_cpu` handshake and checks read data against expected values. It reports pass/fail, so cache-hierarchy benches and on-chip self-test can run coherence sequences without hand-timed stimulus. One instance sits in front of each L1 and runs on that L1's clock.

## Interface
- `DEPTH`, 64: request table entries; index width is `$clog2(DEPTH)`.
- `GAP_CYC`, 1: idle cycles with `ce_cpu` low between requests; must be ≥1.
- `TIMEOUT_CYC`, 1024: maximum cycles to wait for `RDY_cpu` per request.
- `clk` in 1: clock; single clock domain, same clock as the attached L1.
- `reset` in 1: synchronous, active-high.
- `prog_we` in 1: table write strobe.
- `prog_addr` in $clog2(DEPTH): table write index.
- `prog_data` in 34: table entry {chk, rw, addr[23:0], data[7:0]}.
- `num_req` in $clog2(DEPTH)+1: number of entries to run; sampled at `start`.
- `start` in 1: run pulse.
- `addr_cpu` out 24: request address.
- `data_cpu_wr` out 8: write data; drives the cache's `data_cpu_in`.
- `data_cpu_rd` in 8: read data; from the cache's `data_cpu_out`.
- `rw_cpu` out 1: 1 = read, 0 = write.
- `ce_cpu` out 1: request valid.
- `RDY_cpu` in 1: cache completion.
- `busy` out 1: a run is in progress.
- `done` out 1: sticky run-complete flag.
- `pass` out 1: valid when `done`; 1 = no errors.
- `err_cnt` out 8: saturating mismatch plus timeout count.
- `timeout` out 1: sticky; the run aborted on a missing `RDY_cpu`.
- `last_rd` out 8: last captured read byte.

## Operation
- Reset values: all outputs are 0, except `rw_cpu` = 1. Table contents are not reset.
- `prog_we` writes the table only when not `busy`; while `busy` it is ignored.
- States are IDLE, FETCH, REQ, GAP, DONE.
- IDLE, on `start`:
  - Latch `num_req`, set `idx`=0, clear `done`, `pass`, `err_cnt`, `timeout`.
  - If `num_req`=0, go to DONE with `pass`=1. Otherwise go to FETCH.
- FETCH: synchronous table read of entry `idx` → REQ.
- REQ:
  - Drive `addr_cpu`, `rw_cpu`, `data_cpu_wr` and `ce_cpu`=1 from registers. These hold stable for the whole state.
  - Each cycle, sample `RDY_cpu`.
  - On RDY with a read: capture `last_rd`. If chk=1 and `data_cpu_rd`≠entry data, increment `err_cnt`. Then go to GAP.
  - On RDY with a write: go to GAP.
  - If the wait counter reaches TIMEOUT_CYC−1 without RDY: set `timeout`, increment `err_cnt`, go to DONE.
- GAP:
  - `ce_cpu`=0 for GAP_CYC cycles.
  - Then, if `idx`=`num_req`−1, go to DONE; else `idx`++ and go to FETCH.
- DONE:
  - `ce_cpu`=0, `busy`=0, `done`=1, `pass`=(`err_cnt`=0).
  - The next `start` begins a new run directly.
- `busy` is 1 in FETCH, REQ and GAP.
- `start` while `busy` is ignored.
- `RDY_cpu` outside REQ is ignored.
- `err_cnt` saturates at 255.

## Timing
- All outputs are registered.
- `start` is sampled at edge 0. Edge 1 enters FETCH. Edge 2 enters REQ, so `ce_cpu` is high during the cycle after edge 2.
- RDY is sampled high at edge n. Then `ce_cpu` is low after edge n, and `last_rd` and `err_cnt` update at edge n.
- `ce_cpu` is low between consecutive requests for exactly GAP_CYC+1 cycles (GAP plus FETCH).
- A hit that returns RDY in the first REQ cycle gives 1 cycle of `ce_cpu` per request.
- Reset asserted mid-REQ drops `ce_cpu` at that edge and returns to IDLE.

## Structure
- Shared package `cpu_drv_pkg` holds:
  - State enum.
  - Entry field offsets (CHK=33, RW=32, ADDR=31:8, DATA=7:0).
  - `RW_READ`=1'b1 and `RW_WRITE`=1'b0.
- One sub-module, `req_table`: a DEPTH×34 RAM with 1-cycle synchronous read and one write port.

## Test plan
- Write 8'hAB to 24'hF20000, then checked read of 24'hF20000 expecting AB, against a 1-cycle-RDY model → two `ce_cpu` pulses, GAP_CYC+1 low cycles between them, `last_rd`=AB, `pass`=1, `err_cnt`=0.
- Checked read of 24'h245678 expecting 8'h5A while the model returns 8'h3C → `err_cnt`=1, `pass`=0, `last_rd`=3C.
- Model delays RDY 14 cycles on a write of 8'h37 to 24'h56AD34 → `ce_cpu` stays high 14 cycles with addr/data stable; `pass`=1.
- Model never asserts RDY, with TIMEOUT_CYC=16 → `ce_cpu` high for exactly 16 cycles, then `timeout`=1, `done`=1, `pass`=0, `err_cnt`=1.
- `num_req`=0 → `done`=1 and `pass`=1 two edges after `start`; `ce_cpu` never rises.
- Reset mid-REQ, then `start` and `prog_we` pulsed while `busy` → `ce_cpu` drops at the reset edge; the later `start` and `prog_we` have no effect while `busy`; a fresh `start` after reset reruns from entry 0.
